// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
//
// Purpose
//   Serial-in / parallel-out deserialiser placed between a serial link front
//   end and the word-level datapath. Serial bits qualified by in_valid are
//   gathered into WIDTH-bit frames. Each completed frame is presented on a
//   valid/ready output handshake. Frames may run back to back with no dead
//   cycle. A sticky overrun flag is set when an unconsumed word is overwritten.
//
// Parameters
//   WIDTH      bits per frame and output word width (WIDTH >= 2)
//   MSB_FIRST  0: first received bit -> out_data[0]
//              1: first received bit -> out_data[WIDTH-1]
//   CNT_W      width of the bit counter and of the bit_count port
//
// Ports
//   clk        clock, rising edge
//   res        asynchronous active-high reset
//   in_bit     serial data bit
//   in_valid   in_bit is sampled on this edge
//   clear      synchronous frame restart: drops the partial frame, clears overrun
//   out_ready  downstream accepts out_data this cycle
//   out_data   assembled word, held after consumption
//   out_valid  out_data holds an unconsumed word
//   overrun    sticky: a word was overwritten before it was accepted
//   bit_count  bits captured in the current partial frame, 0..WIDTH-1
// -----------------------------------------------------------------------------
module sipo_deser #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  // Counter value of the final bit of a frame.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Partial frame being assembled; bits land directly in their output position.
  logic [WIDTH-1:0] shift_q;
  // Partial frame with the current in_bit merged in at its position.
  logic [WIDTH-1:0] frame_next;
  // Output bit position of the bit currently being received.
  logic [CNT_W-1:0] pos;

  logic capture;   // a bit is accepted on this edge
  logic complete;  // the accepted bit finishes a frame
  logic consume;   // the pending output word is taken downstream

  // clear has priority: a bit arriving with clear is dropped.
  assign capture  = in_valid & ~clear;
  assign complete = capture & (bit_count == LAST_BIT);
  assign consume  = out_valid & out_ready;

  // Bit order is resolved at the write position, so the completed word needs
  // no reordering and the frame register never has to shift.
  assign pos = MSB_FIRST ? (LAST_BIT - bit_count) : bit_count;

  always_comb begin
    // NOTE: frame_next is assigned in full before the loop so every path
    // drives every bit; a missing default here would infer a latch.
    frame_next = shift_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos == CNT_W'(i)) begin
        frame_next[i] = in_bit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture state: frame register and bit counter.
  // ---------------------------------------------------------------------------
  // NOTE: all state in clocked blocks uses non-blocking assignment so every
  // register samples the pre-edge values of the others, independent of the
  // order in which the blocks are evaluated.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (clear) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (capture) begin
      if (complete) begin
        // The finished word moves to out_data; the next valid bit, even on
        // the very next edge, starts a fresh frame at position 0.
        shift_q   <= '0;
        bit_count <= '0;
      end else begin
        shift_q   <= frame_next;
        bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word, handshake and overrun.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A completion wins over a consumption on the same edge: the old word
      // leaves, the new word takes its place and out_valid stays high.
      if (complete) begin
        out_data  <= frame_next;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end

      // Overrun marks a pending word replaced without being accepted. clear
      // never coincides with a completion, so the two branches do not race.
      if (clear) begin
        overrun <= 1'b0;
      end else if (complete && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
//
// Self-checking bench for sipo_deser (WIDTH=10). Two instances share all
// inputs: one LSB-first, one MSB-first, so every stream checks both orders.
// A table of per-cycle vectors covers plain and bubbled frames; hand-written
// sequences cover back-to-back frames, overrun, clear and async reset.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

  localparam int WIDTH = 10;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             res;
  logic             in_bit;
  logic             in_valid;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] data_lsb;
  logic             valid_lsb;
  logic             overrun_lsb;
  logic [CNT_W-1:0] count_lsb;
  logic [WIDTH-1:0] data_msb;
  logic             valid_msb;
  logic             overrun_msb;
  logic [CNT_W-1:0] count_msb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .res       (res),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clear     (clear),
    .out_ready (out_ready),
    .out_data  (data_lsb),
    .out_valid (valid_lsb),
    .overrun   (overrun_lsb),
    .bit_count (count_lsb)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .res       (res),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clear     (clear),
    .out_ready (out_ready),
    .out_data  (data_msb),
    .out_valid (valid_msb),
    .overrun   (overrun_msb),
    .bit_count (count_msb)
  );

  typedef struct {
    logic             in_bit;
    logic             in_valid;
    logic             clear;
    logic             out_ready;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] exp_data_msb;
    logic             exp_valid;
    logic             exp_overrun;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  vec_t vecs[32];
  int   n_vecs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic b, input logic v, input logic c, input logic r,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] dm,
                         input logic ev, input logic eo, input int cnt);
    vecs[n_vecs].in_bit       = b;
    vecs[n_vecs].in_valid     = v;
    vecs[n_vecs].clear        = c;
    vecs[n_vecs].out_ready    = r;
    vecs[n_vecs].exp_data     = d;
    vecs[n_vecs].exp_data_msb = dm;
    vecs[n_vecs].exp_valid    = ev;
    vecs[n_vecs].exp_overrun  = eo;
    vecs[n_vecs].exp_count    = CNT_W'(cnt);
    n_vecs++;
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle past it.
  task automatic cycle(input logic b, input logic v, input logic c, input logic r);
    in_bit    = b;
    in_valid  = v;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Send bits first..last of word (bit k of the frame = word[k]).
  task automatic send_word(input logic [WIDTH-1:0] word, input int first, input int last,
                           input logic r);
    for (int k = first; k <= last; k++) begin
      cycle(word[k], 1'b1, 1'b0, r);
    end
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] dm, input logic v,
                             input logic o, input int cnt);
    check({tag, " data"},     32'(data_lsb),    32'(d));
    check({tag, " data_msb"}, 32'(data_msb),    32'(dm));
    check({tag, " valid"},    32'(valid_lsb),   32'(v));
    check({tag, " overrun"},  32'(overrun_lsb), 32'(o));
    check({tag, " count"},    32'(count_lsb),   32'(cnt));
  endtask

  initial begin
    // Reference stream 1,0,1,1,0,0,0,0,0,1: frame bit k = stream[k].
    logic [WIDTH-1:0] stream;
    stream = 10'b10_0000_1101;

    // Bubbled frame: every bit followed by an in_valid=0 cycle carrying junk.
    for (int k = 0; k < WIDTH; k++) begin
      add_vec(stream[k], 1'b1, 1'b0, 1'b1,
              (k == 9) ? 10'h20D : 10'h000, (k == 9) ? 10'h2C1 : 10'h000,
              k == 9, 1'b0, (k + 1) % WIDTH);
      add_vec(~stream[k], 1'b0, 1'b0, 1'b1,
              (k == 9) ? 10'h20D : 10'h000, (k == 9) ? 10'h2C1 : 10'h000,
              1'b0, 1'b0, (k + 1) % WIDTH);
    end
    // Same stream on consecutive edges; out_valid high for exactly one cycle.
    for (int k = 0; k < WIDTH; k++) begin
      add_vec(stream[k], 1'b1, 1'b0, 1'b1, 10'h20D, 10'h2C1,
              k == 9, 1'b0, (k + 1) % WIDTH);
    end
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 10'h20D, 10'h2C1, 1'b0, 1'b0, 0);

    // Reset: asynchronous, visible before the first edge.
    res = 1'b1; in_bit = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #3;
    check_state("reset", 10'h000, 10'h000, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #3;
    res = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < n_vecs; i++) begin
      cycle(vecs[i].in_bit, vecs[i].in_valid, vecs[i].clear, vecs[i].out_ready);
      check_state($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_data_msb,
                  vecs[i].exp_valid, vecs[i].exp_overrun, vecs[i].exp_count);
    end

    // Back-to-back frames with out_ready low: second word overwrites first.
    send_word(10'h155, 0, 9, 1'b0);
    check_state("b2b first", 10'h155, 10'h2AA, 1'b1, 1'b0, 0);
    send_word(10'h2AA, 0, 4, 1'b0);
    check_state("b2b hold", 10'h155, 10'h2AA, 1'b1, 1'b0, 5);
    send_word(10'h2AA, 5, 9, 1'b0);
    check_state("b2b second", 10'h2AA, 10'h155, 1'b1, 1'b1, 0);
    check("b2b msb overrun", 32'(overrun_msb), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_state("b2b clear", 10'h2AA, 10'h155, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_state("b2b drain", 10'h2AA, 10'h155, 1'b0, 1'b0, 0);

    // Clear mid-frame, then clear together with a valid bit (bit dropped).
    send_word(10'h3FF, 0, 3, 1'b1);
    check("clr partial count", 32'(count_lsb), 32'd4);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr drop count", 32'(count_lsb), 32'd0);
    check("clr msb count", 32'(count_msb), 32'd0);
    send_word(10'h0C3, 0, 9, 1'b0);
    check_state("clr frame", 10'h0C3, 10'h30C, 1'b1, 1'b0, 0);

    // Completion while a word is pending and out_ready rises on that edge.
    send_word(10'h3A5, 0, 8, 1'b0);
    check_state("simul wait", 10'h0C3, 10'h30C, 1'b1, 1'b0, 9);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_state("simul done", 10'h3A5, 10'h297, 1'b1, 1'b0, 0);
    check("simul msb valid", 32'(valid_msb), 32'd1);

    // Async reset between edges with a pending word, overrun and a partial frame.
    send_word(10'h155, 0, 9, 1'b0);
    check("pre-res overrun", 32'(overrun_lsb), 32'd1);
    send_word(10'h3FF, 0, 2, 1'b0);
    check("pre-res count", 32'(count_lsb), 32'd3);
    #2;
    res = 1'b1;
    #1;
    check_state("async res", 10'h000, 10'h000, 1'b0, 1'b0, 0);
    check("async res msb valid", 32'(valid_msb), 32'd0);
    #1;
    res = 1'b0;
    send_word(10'h155, 0, 9, 1'b1);
    check_state("post-res frame", 10'h155, 10'h2AA, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
